// File: rtl/control_pipe_if.sv
// rtl/control_pipe_if.sv - decode-side control inputs and pipelined control outputs of control_pipe
interface control_pipe_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  // Decode stage
  logic             id_valid;
  logic             id_reg_dest;
  logic             id_branch;
  logic             id_mem_read;
  logic             id_mem_to_reg;
  logic             id_mem_write;
  logic             id_alu_src;
  logic             id_reg_write;
  logic [1:0]       id_alu_op;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic [REG_W-1:0] id_rd;
  logic             ex_zero;
  // Hazard / branch
  logic             stall;
  logic             flush;
  logic             branch_taken;
  // EX stage
  logic             ex_valid;
  logic             ex_alu_src;
  logic             ex_branch;
  logic             ex_mem_read;
  logic [1:0]       ex_alu_op;
  logic [REG_W-1:0] ex_rs;
  logic [REG_W-1:0] ex_rt;
  logic [REG_W-1:0] ex_dst;
  // MEM stage
  logic             mem_valid;
  logic             mem_read;
  logic             mem_write;
  logic             mem_reg_write;
  logic             mem_to_reg;
  logic [REG_W-1:0] mem_dst;
  // WB stage
  logic             wb_valid;
  logic             wb_reg_write;
  logic             wb_mem_to_reg;
  logic [REG_W-1:0] wb_dst;
  // Event counters
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Decoder/datapath side
  modport master (
    output id_valid, id_reg_dest, id_branch, id_mem_read, id_mem_to_reg,
           id_mem_write, id_alu_src, id_reg_write, id_alu_op, id_rs, id_rt,
           id_rd, ex_zero,
    input  stall, flush, branch_taken,
           ex_valid, ex_alu_src, ex_branch, ex_mem_read, ex_alu_op, ex_rs,
           ex_rt, ex_dst,
           mem_valid, mem_read, mem_write, mem_reg_write, mem_to_reg, mem_dst,
           wb_valid, wb_reg_write, wb_mem_to_reg, wb_dst,
           stall_cnt, flush_cnt
  );

  // Pipeline control side
  modport slave (
    input  id_valid, id_reg_dest, id_branch, id_mem_read, id_mem_to_reg,
           id_mem_write, id_alu_src, id_reg_write, id_alu_op, id_rs, id_rt,
           id_rd, ex_zero,
    output stall, flush, branch_taken,
           ex_valid, ex_alu_src, ex_branch, ex_mem_read, ex_alu_op, ex_rs,
           ex_rt, ex_dst,
           mem_valid, mem_read, mem_write, mem_reg_write, mem_to_reg, mem_dst,
           wb_valid, wb_reg_write, wb_mem_to_reg, wb_dst,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/control_pipe.sv
// rtl/control_pipe.sv - ID/EX/MEM/WB control pipeline with load-use stall and beq flush
module control_pipe #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input logic           clk,
  input logic           rst_n,
  control_pipe_if.slave bus
);

  // ID/EX
  logic             ex_valid_q,      ex_valid_d;
  logic             ex_alu_src_q,    ex_alu_src_d;
  logic             ex_branch_q,     ex_branch_d;
  logic             ex_mem_read_q,   ex_mem_read_d;
  logic             ex_mem_write_q,  ex_mem_write_d;
  logic             ex_reg_write_q,  ex_reg_write_d;
  logic             ex_mem_to_reg_q, ex_mem_to_reg_d;
  logic [1:0]       ex_alu_op_q,     ex_alu_op_d;
  logic [REG_W-1:0] ex_rs_q,         ex_rs_d;
  logic [REG_W-1:0] ex_rt_q,         ex_rt_d;
  logic [REG_W-1:0] ex_dst_q,        ex_dst_d;
  // EX/MEM
  logic             mem_valid_q;
  logic             mem_read_q;
  logic             mem_write_q;
  logic             mem_reg_write_q;
  logic             mem_to_reg_q;
  logic [REG_W-1:0] mem_dst_q;
  // MEM/WB
  logic             wb_valid_q;
  logic             wb_reg_write_q;
  logic             wb_mem_to_reg_q;
  logic [REG_W-1:0] wb_dst_q;
  // Counters
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic             hazard;
  logic             branch_taken;
  logic             stall;
  logic             id_wr;
  logic [REG_W-1:0] id_dst;

  // Hazard detection, branch resolution and sanitised ID/EX next state
  always_comb begin
    hazard       = bus.id_valid & ex_valid_q & ex_mem_read_q & (ex_dst_q != '0) &
                   ((ex_dst_q == bus.id_rs) | (ex_dst_q == bus.id_rt));
    branch_taken = ex_valid_q & ex_branch_q & bus.ex_zero;
    stall        = hazard & ~branch_taken;

    // A known-0 qualifier selects the constant arm, so an undriven
    // id_reg_dest/id_mem_to_reg never leaks into the captured fields.
    id_wr  = bus.id_valid & bus.id_reg_write;
    id_dst = id_wr ? (bus.id_reg_dest ? bus.id_rd : bus.id_rt) : '0;

    ex_valid_d      = 1'b0;
    ex_alu_src_d    = 1'b0;
    ex_branch_d     = 1'b0;
    ex_mem_read_d   = 1'b0;
    ex_mem_write_d  = 1'b0;
    ex_reg_write_d  = 1'b0;
    ex_mem_to_reg_d = 1'b0;
    ex_alu_op_d     = '0;
    ex_rs_d         = '0;
    ex_rt_d         = '0;
    ex_dst_d        = '0;
    if (!stall && !branch_taken && bus.id_valid) begin
      ex_valid_d      = 1'b1;
      ex_alu_src_d    = bus.id_alu_src;
      ex_branch_d     = bus.id_branch;
      ex_mem_read_d   = bus.id_mem_read;
      ex_mem_write_d  = bus.id_mem_write;
      ex_reg_write_d  = id_wr & (id_dst != '0);
      ex_mem_to_reg_d = bus.id_mem_read ? bus.id_mem_to_reg : 1'b0;
      ex_alu_op_d     = bus.id_alu_op;
      ex_rs_d         = bus.id_rs;
      ex_rt_d         = bus.id_rt;
      ex_dst_d        = id_dst;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    flush_cnt_d = flush_cnt_q;
    if (branch_taken && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // Pipeline registers and counters; reset discards every in-flight entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q      <= 1'b0;
      ex_alu_src_q    <= 1'b0;
      ex_branch_q     <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      ex_mem_write_q  <= 1'b0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_to_reg_q <= 1'b0;
      ex_alu_op_q     <= '0;
      ex_rs_q         <= '0;
      ex_rt_q         <= '0;
      ex_dst_q        <= '0;
      mem_valid_q     <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_reg_write_q <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      mem_dst_q       <= '0;
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_dst_q        <= '0;
      stall_cnt_q     <= '0;
      flush_cnt_q     <= '0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_alu_src_q    <= ex_alu_src_d;
      ex_branch_q     <= ex_branch_d;
      ex_mem_read_q   <= ex_mem_read_d;
      ex_mem_write_q  <= ex_mem_write_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_mem_to_reg_q <= ex_mem_to_reg_d;
      ex_alu_op_q     <= ex_alu_op_d;
      ex_rs_q         <= ex_rs_d;
      ex_rt_q         <= ex_rt_d;
      ex_dst_q        <= ex_dst_d;
      // EX/MEM and MEM/WB never stall; the branch moves on as a non-writer
      mem_valid_q     <= ex_valid_q;
      mem_read_q      <= ex_mem_read_q;
      mem_write_q     <= ex_mem_write_q;
      mem_reg_write_q <= ex_reg_write_q;
      mem_to_reg_q    <= ex_mem_to_reg_q;
      mem_dst_q       <= ex_dst_q;
      wb_valid_q      <= mem_valid_q;
      wb_reg_write_q  <= mem_reg_write_q;
      wb_mem_to_reg_q <= mem_to_reg_q;
      wb_dst_q        <= mem_dst_q;
      stall_cnt_q     <= stall_cnt_d;
      flush_cnt_q     <= flush_cnt_d;
    end
  end

  assign bus.stall         = stall;
  assign bus.flush         = branch_taken;
  assign bus.branch_taken  = branch_taken;
  assign bus.ex_valid      = ex_valid_q;
  assign bus.ex_alu_src    = ex_alu_src_q;
  assign bus.ex_branch     = ex_branch_q;
  assign bus.ex_mem_read   = ex_mem_read_q;
  assign bus.ex_alu_op     = ex_alu_op_q;
  assign bus.ex_rs         = ex_rs_q;
  assign bus.ex_rt         = ex_rt_q;
  assign bus.ex_dst        = ex_dst_q;
  assign bus.mem_valid     = mem_valid_q;
  assign bus.mem_read      = mem_read_q;
  assign bus.mem_write     = mem_write_q;
  assign bus.mem_reg_write = mem_reg_write_q;
  assign bus.mem_to_reg    = mem_to_reg_q;
  assign bus.mem_dst       = mem_dst_q;
  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_reg_write  = wb_reg_write_q;
  assign bus.wb_mem_to_reg = wb_mem_to_reg_q;
  assign bus.wb_dst        = wb_dst_q;
  assign bus.stall_cnt     = stall_cnt_q;
  assign bus.flush_cnt     = flush_cnt_q;

endmodule
